hc595_chain_ctrl: RTL and testbench



---
 rtl/hc595_chain_ctrl_pkg.sv | 27 ++
 rtl/hc595_chain_ctrl_if.sv | 31 +++
 rtl/hc595_chain_ctrl.sv | 132 +++++++++++++
 tb/tb_hc595_chain_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hc595_chain_ctrl_pkg.sv
// rtl/hc595_chain_ctrl_pkg.sv - shared types, defaults and width helpers for the 595 chain driver
//
// Purpose : FSM state encoding, default chain/divider constants and the
//           counter-width helpers used by the driver and its interface.
// Ports   : none (package).
package hc595_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam int DEF_CHAIN_N = 2;
  localparam int DEF_CLK_DIV = 2;

  // Bit counter width: one spare bit above $clog2 so B itself is representable.
  function automatic int shift_cnt_w(input int b);
    return $clog2(b) + 1;
  endfunction

  // Divider counter width: must hold 2*D-1 (a full shcp period).
  function automatic int div_cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/hc595_chain_ctrl_if.sv
// rtl/hc595_chain_ctrl_if.sv - load/busy/done handshake plus 595 pin bundle
//
// Purpose : groups the parallel-load handshake and the serial 595 pins.
// Ports   : load, data[B-1:0], blank  (master -> driver)
//           busy, done, ds, shcp, stcp, oe  (driver -> master / 595 chain)
// Modports: master = requester side, slave = the hc595_chain_ctrl driver.
interface hc595_chain_ctrl_if
  import hc595_pkg::*;
#(
  parameter int B = DEF_CHAIN_N * 8
);
  logic         load;
  logic [B-1:0] data;
  logic         blank;
  logic         busy;
  logic         done;
  logic         ds;
  logic         shcp;
  logic         stcp;
  logic         oe;

  modport master (
    output load, data, blank,
    input  busy, done, ds, shcp, stcp, oe
  );

  modport slave (
    input  load, data, blank,
    output busy, done, ds, shcp, stcp, oe
  );
endinterface

// File: rtl/hc595_chain_ctrl.sv
// rtl/hc595_chain_ctrl.sv - serial driver for a chain of cascaded 74HC595 registers
//
// Purpose : accepts a B-bit word (B = CHAIN_N*8) on load, shifts it out on
//           ds/shcp with a 2*CLK_DIV-cycle bit period, pulses stcp for
//           CLK_DIV cycles, then pulses done. oe stays high (blanked) until
//           the first completed latch, then follows blank one cycle later.
// Ports   : sys_clk   - system clock
//           sys_rst_n - synchronous active-low reset
//           bus       - hc595_chain_ctrl_if.slave (load/data/blank in,
//                       busy/done/ds/shcp/stcp/oe out, all registered)
module hc595_chain_ctrl
  import hc595_pkg::*;
#(
  parameter int CHAIN_N   = DEF_CHAIN_N,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  hc595_chain_ctrl_if.slave    bus
);

  localparam int B  = CHAIN_N * 8;
  localparam int DW = div_cnt_w(CLK_DIV);
  localparam int BW = shift_cnt_w(B);

  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(B - 1);

  state_t        r_state;
  logic [B-1:0]  r_sr;
  logic [DW-1:0] r_div_cnt;
  logic [BW-1:0] r_bit_cnt;
  logic          r_latched_once;
  logic          r_ds;
  logic          r_shcp;
  logic          r_stcp;
  logic          r_oe;
  logic          r_busy;
  logic          r_done;

  logic          w_first_bit;
  logic          w_next_bit;
  logic [B-1:0]  w_sr_rot;

  // The shift register rotates rather than shifts so the outgoing bit is
  // always at the same end; the next bit to present is its neighbour.
  assign w_first_bit = MSB_FIRST ? bus.data[B-1] : bus.data[0];
  assign w_next_bit  = MSB_FIRST ? r_sr[B-2]     : r_sr[1];
  assign w_sr_rot    = MSB_FIRST ? {r_sr[B-2:0], r_sr[B-1]}
                                 : {r_sr[0], r_sr[B-1:1]};

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state        <= ST_IDLE;
      r_sr           <= '0;
      r_div_cnt      <= '0;
      r_bit_cnt      <= '0;
      r_latched_once <= 1'b0;
      r_ds           <= 1'b0;
      r_shcp         <= 1'b0;
      r_stcp         <= 1'b0;
      r_oe           <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Flag is sampled before it updates, so oe drops the cycle after done.
      r_oe   <= r_latched_once ? bus.blank : 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (bus.load) begin
            r_sr      <= bus.data;
            r_ds      <= w_first_bit;
            r_shcp    <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // r_div_cnt is the position of the currently visible cycle in the bit.
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            r_shcp    <= 1'b0;
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              r_stcp    <= 1'b1;
              r_state   <= ST_LATCH;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_sr      <= w_sr_rot;
              r_ds      <= w_next_bit;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            if (r_div_cnt == DIV_HALF) begin
              r_shcp <= 1'b1;
            end
          end
        end

        ST_LATCH: begin
          if (r_div_cnt == DIV_HALF) begin
            r_div_cnt      <= '0;
            r_stcp         <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b1;
            r_latched_once <= 1'b1;
            r_state        <= ST_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ds   = r_ds;
  assign bus.shcp = r_shcp;
  assign bus.stcp = r_stcp;
  assign bus.oe   = r_oe;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_hc595_chain_ctrl.sv
// tb/tb_hc595_chain_ctrl.sv - directed self-checking bench for hc595_chain_ctrl
module tb_hc595_chain_ctrl;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  logic rst_n_c = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hc595_chain_ctrl_if #(.B(16)) ifa ();
  hc595_chain_ctrl_if #(.B(16)) ifb ();
  hc595_chain_ctrl_if #(.B(8))  ifc ();

  hc595_chain_ctrl #(.CHAIN_N(2), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n_a), .bus(ifa)
  );
  hc595_chain_ctrl #(.CHAIN_N(2), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n_b), .bus(ifb)
  );
  hc595_chain_ctrl #(.CHAIN_N(1), .CLK_DIV(1), .MSB_FIRST(1'b1)) u_dut_c (
    .sys_clk(clk), .sys_rst_n(rst_n_c), .bus(ifc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] pat;
    logic [7:0]  pat8;
    int rises;
    logic prev;
    int ndone;
    int done_at [2];

    ifa.load = 0; ifa.data = '0; ifa.blank = 0;
    ifb.load = 0; ifb.data = '0; ifb.blank = 0;
    ifc.load = 0; ifc.data = '0; ifc.blank = 0;
    repeat (3) tick();
    rst_n_a = 1; rst_n_b = 1; rst_n_c = 1;
    tick();

    check("rst_ds",   ifa.ds,   0);
    check("rst_shcp", ifa.shcp, 0);
    check("rst_stcp", ifa.stcp, 0);
    check("rst_oe",   ifa.oe,   1);
    check("rst_busy", ifa.busy, 0);
    check("rst_done", ifa.done, 0);

    // A1: MSB-first A5C3 with full timing trace.
    pat = 16'hA5C3;
    ifa.data = pat; ifa.load = 1;
    tick();
    ifa.load = 0; ifa.data = 16'h0000;
    rises = 0; prev = 0;
    for (int c = 1; c <= 68; c++) begin
      if (c <= 64) begin
        check("a1_ds",   ifa.ds,   pat[15 - (c - 1) / 4]);
        check("a1_shcp", ifa.shcp, ((c - 1) % 4) >= 2);
      end else if (c <= 66) begin
        check("a1_ds_hold",   ifa.ds,   1);
        check("a1_shcp_latch", ifa.shcp, 0);
      end
      check("a1_busy", ifa.busy, (c <= 66));
      check("a1_done", ifa.done, (c == 67));
      check("a1_stcp", ifa.stcp, (c >= 65 && c <= 66));
      check("a1_oe",   ifa.oe,   (c <= 67));
      if (ifa.shcp && !prev) rises++;
      prev = ifa.shcp;
      tick();
    end
    check("a1_shcp_rises", rises, 16);

    // oe follows blank with one cycle of latency after the first latch.
    check("oe_on", ifa.oe, 0);
    ifa.blank = 1;
    tick();
    check("oe_blank", ifa.oe, 1);
    ifa.blank = 0;
    tick();
    check("oe_unblank", ifa.oe, 0);

    // A2: load pulses during a transfer are ignored.
    pat = 16'hF00F;
    ifa.data = pat; ifa.load = 1;
    tick();
    ifa.load = 0;
    ndone = 0; done_at[0] = 0;
    for (int c = 1; c <= 80; c++) begin
      if (ifa.done) begin
        ndone++;
        done_at[0] = c;
      end
      if (c == 1)  check("a2_ds_first", ifa.ds, 1);
      if (c == 61) check("a2_ds_last",  ifa.ds, 1);
      if (c == 10 || c == 40) begin
        ifa.load = 1; ifa.data = 16'h0000;
      end else begin
        ifa.load = 0;
      end
      tick();
    end
    check("a2_ndone",   ndone, 1);
    check("a2_done_at", done_at[0], 67);

    // A3: load held high gives back-to-back transfers.
    ifa.data = 16'h00FF; ifa.load = 1;
    tick();
    ifa.data = 16'h8000;
    ndone = 0; done_at[0] = 0; done_at[1] = 0;
    for (int c = 1; c <= 136; c++) begin
      if (ifa.done) begin
        if (ndone < 2) done_at[ndone] = c;
        ndone++;
      end
      if (c == 1)  check("a3_ds_first", ifa.ds, 0);
      if (c == 67) check("a3_busy_gap", ifa.busy, 0);
      if (c == 68) begin
        check("a3_busy2",  ifa.busy, 1);
        check("a3_shcp2",  ifa.shcp, 0);
        check("a3_ds2",    ifa.ds,   1);
      end
      if (c == 72) check("a3_ds2_bit1", ifa.ds, 0);
      if (c == 134) ifa.load = 0;
      tick();
    end
    check("a3_ndone", ndone, 2);
    check("a3_done0", done_at[0], 67);
    check("a3_done1", done_at[1], 134);

    // B: LSB-first, only bit 0 set.
    ifb.data = 16'h0001; ifb.load = 1;
    tick();
    ifb.load = 0;
    for (int c = 1; c <= 68; c++) begin
      if (c <= 66) check("b_ds", ifb.ds, (c <= 4));
      check("b_done", ifb.done, (c == 67));
      tick();
    end

    // C1: one chip, CLK_DIV=1, full transfer.
    pat8 = 8'h3C;
    ifc.data = pat8; ifc.load = 1;
    tick();
    ifc.load = 0;
    for (int c = 1; c <= 19; c++) begin
      if (c <= 16) begin
        check("c1_ds",   ifc.ds,   pat8[7 - (c - 1) / 2]);
        check("c1_shcp", ifc.shcp, ((c - 1) % 2) == 1);
      end
      check("c1_stcp", ifc.stcp, (c == 17));
      check("c1_busy", ifc.busy, (c <= 17));
      check("c1_done", ifc.done, (c == 18));
      check("c1_oe",   ifc.oe,   (c <= 18));
      tick();
    end

    // C2: reset in the middle of a transfer.
    ifc.data = 8'hA5; ifc.load = 1;
    tick();
    ifc.load = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) rst_n_c = 0;
      tick();
    end
    check("c2_ds",   ifc.ds,   0);
    check("c2_shcp", ifc.shcp, 0);
    check("c2_stcp", ifc.stcp, 0);
    check("c2_oe",   ifc.oe,   1);
    check("c2_busy", ifc.busy, 0);
    check("c2_done", ifc.done, 0);
    rst_n_c = 1;
    ndone = 0;
    for (int c = 6; c <= 40; c++) begin
      if (ifc.done) ndone++;
      tick();
    end
    check("c2_ndone", ndone, 0);
    check("c2_oe_still_off", ifc.oe, 1);

    // C3: fresh transfer after reset.
    ifc.data = 8'hFF; ifc.load = 1;
    tick();
    ifc.load = 0;
    ndone = 0; done_at[0] = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 16) check("c3_ds", ifc.ds, 1);
      if (ifc.done) begin
        ndone++;
        done_at[0] = c;
      end
      if (c == 19) check("c3_oe_on", ifc.oe, 0);
      tick();
    end
    check("c3_ndone",   ndone, 1);
    check("c3_done_at", done_at[0], 18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
